// File: rtl/sdram_stream_sequencer_pkg.sv
// sdram_seq_pkg: shared state encoding, word size and chunk sizing helper for the stream sequencer.
package sdram_seq_pkg;
  typedef logic [2:0] state_t;
  localparam state_t IDLE   = 3'd0;
  localparam state_t ISSUE  = 3'd1;
  localparam state_t RUN    = 3'd2;
  localparam state_t DRAIN  = 3'd3;
  localparam state_t FINISH = 3'd4;
  localparam int BYTES_PER_WORD = 2;
  function automatic logic [31:0] chunk_min(input logic [31:0] rem, input logic [31:0] lim);
    return (rem < lim) ? rem : lim;
  endfunction
endpackage

// File: rtl/sdram_stream_sequencer_if.sv
// sdram_stream_sequencer_if: command, read-master and output-stream signals of the sequencer.
// SDRAM_SEQ_CHECKSUM_EN adds the checksum output.
interface sdram_stream_sequencer_if #(
  parameter int ADDR_W = 25,
  parameter int DATA_W = 16
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [ADDR_W-1:0] cmd_base;
  logic [ADDR_W-1:0] cmd_length;
  logic              busy;
  logic              xfer_done;
  logic              rm_fixed_location;
  logic [ADDR_W-1:0] rm_read_base;
  logic [ADDR_W-1:0] rm_read_length;
  logic              rm_go;
  logic              rm_done;
  logic              rm_early_done;
  logic              rm_read_buffer;
  logic [DATA_W-1:0] rm_data;
  logic              rm_data_available;
  logic [DATA_W-1:0] m_data;
  logic              m_valid;
  logic              m_ready;
  logic              m_last;
`ifdef SDRAM_SEQ_CHECKSUM_EN
  logic [DATA_W-1:0] checksum;
`endif
  modport slave (
    input  cmd_valid, cmd_base, cmd_length, rm_done, rm_early_done, rm_data, rm_data_available, m_ready,
    output cmd_ready, busy, xfer_done, rm_fixed_location, rm_read_base, rm_read_length, rm_go,
           rm_read_buffer, m_data, m_valid, m_last
`ifdef SDRAM_SEQ_CHECKSUM_EN
    , output checksum
`endif
  );
  modport master (
    output cmd_valid, cmd_base, cmd_length, rm_done, rm_early_done, rm_data, rm_data_available, m_ready,
    input  cmd_ready, busy, xfer_done, rm_fixed_location, rm_read_base, rm_read_length, rm_go,
           rm_read_buffer, m_data, m_valid, m_last
`ifdef SDRAM_SEQ_CHECKSUM_EN
    , input checksum
`endif
  );
endinterface

// File: rtl/sdram_stream_sequencer_out_reg.sv
// sdram_seq_out_reg: one-entry valid/ready output register carrying data and a last flag.
module sdram_seq_out_reg #(
  parameter int DATA_W = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              load_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              last_i,
  input  logic              ready_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o,
  output logic              last_o
);
  logic              valid_q, valid_d, last_q;
  logic [DATA_W-1:0] data_q;
  assign valid_d = load_i | (valid_q & ~ready_i);
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      if (load_i) begin
        data_q <= data_i;
        last_q <= last_i;
      end
    end
  end
  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign last_o  = last_q;
endmodule

// File: rtl/sdram_stream_sequencer.sv
// sdram_stream_sequencer: splits a byte read command into read-master chunks and streams the words out.
// SDRAM_SEQ_CHECKSUM_EN adds a running 16-bit sum of the words delivered in the current transfer.
import sdram_seq_pkg::*;
module sdram_stream_sequencer #(
  parameter int ADDR_W      = 25,
  parameter int DATA_W      = 16,
  parameter int CHUNK_BYTES = 4096
) (
  input logic                   clk_clk,
  input logic                   reset_reset_n,
  sdram_stream_sequencer_if.slave bus
);
  localparam logic [ADDR_W-1:0] WMASK = ~ADDR_W'(BYTES_PER_WORD - 1);
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d, rem_q, rem_d, words_q, words_d;
  logic [ADDR_W-1:0] rd_base_q, rd_base_d, rd_len_q, rd_len_d, chunk, len_in;
  logic              go_q, go_d, pop, last_pop, m_valid, m_last;
  logic [DATA_W-1:0] m_data;
  logic              unused_ok;
  assign unused_ok = bus.rm_early_done;
  assign len_in    = bus.cmd_length & WMASK;
  assign chunk     = ADDR_W'(chunk_min(32'(rem_q), CHUNK_BYTES));
  assign pop       = (state_q == RUN) && bus.rm_data_available && (!m_valid || bus.m_ready) && (words_q != '0);
  assign last_pop  = (words_q == ADDR_W'(1)) && (rem_q == rd_len_q);
  // Chunk completion is counted by pops; rm_done only gates the next go.
  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    rem_d     = rem_q;
    words_d   = words_q;
    rd_base_d = rd_base_q;
    rd_len_d  = rd_len_q;
    go_d      = 1'b0;
    case (state_q)
      IDLE: if (bus.cmd_valid) begin
        base_d  = bus.cmd_base & WMASK;
        rem_d   = len_in;
        state_d = (len_in == '0) ? FINISH : ISSUE;
      end
      ISSUE: if (bus.rm_done) begin
        rd_base_d = base_q;
        rd_len_d  = chunk;
        words_d   = chunk / ADDR_W'(BYTES_PER_WORD);
        go_d      = 1'b1;
        state_d   = RUN;
      end
      RUN: if (pop) begin
        words_d = words_q - ADDR_W'(1);
        if (words_q == ADDR_W'(1)) begin
          base_d  = base_q + rd_len_q;
          rem_d   = rem_q - rd_len_q;
          state_d = (rem_q == rd_len_q) ? DRAIN : ISSUE;
        end
      end
      DRAIN:   state_d = (!m_valid || bus.m_ready) ? FINISH : DRAIN;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q   <= IDLE;
      base_q    <= '0;
      rem_q     <= '0;
      words_q   <= '0;
      rd_base_q <= '0;
      rd_len_q  <= '0;
      go_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      rem_q     <= rem_d;
      words_q   <= words_d;
      rd_base_q <= rd_base_d;
      rd_len_q  <= rd_len_d;
      go_q      <= go_d;
    end
  end
  sdram_seq_out_reg #(.DATA_W(DATA_W)) u_out (
    .clk_i  (clk_clk),
    .rst_ni (reset_reset_n),
    .load_i (pop),
    .data_i (bus.rm_data),
    .last_i (last_pop),
    .ready_i(bus.m_ready),
    .valid_o(m_valid),
    .data_o (m_data),
    .last_o (m_last)
  );
`ifdef SDRAM_SEQ_CHECKSUM_EN
  logic [DATA_W-1:0] csum_q;
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) csum_q <= '0;
    else if (state_q == IDLE && bus.cmd_valid) csum_q <= '0;
    else if (m_valid && bus.m_ready) csum_q <= csum_q + m_data;
  end
  assign bus.checksum = csum_q;
`endif
  assign bus.cmd_ready         = (state_q == IDLE);
  assign bus.busy              = (state_q inside {ISSUE, RUN, DRAIN});
  assign bus.xfer_done         = (state_q == FINISH);
  assign bus.rm_fixed_location = 1'b0;
  assign bus.rm_read_base      = rd_base_q;
  assign bus.rm_read_length    = rd_len_q;
  assign bus.rm_go             = go_q;
  assign bus.rm_read_buffer    = pop;
  assign bus.m_data            = m_data;
  assign bus.m_valid           = m_valid;
  assign bus.m_last            = m_last;
endmodule

// File: tb/tb_sdram_stream_sequencer.sv
// tb_sdram_stream_sequencer: scoreboard bench with a read-master/show-ahead buffer model.
module tb_sdram_stream_sequencer;
  localparam int AW = 25;
  localparam int DW = 16;
  localparam int CB = 4096;
  typedef struct packed {logic [AW-1:0] b; logic [AW-1:0] l;} go_t;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;
  sdram_stream_sequencer_if #(.ADDR_W(AW), .DATA_W(DW)) sif ();
  sdram_stream_sequencer #(.ADDR_W(AW), .DATA_W(DW), .CHUNK_BYTES(CB)) dut (
    .clk_clk(clk), .reset_reset_n(rst_n), .bus(sif));
  int n_chk = 0, n_pass = 0, cyc = 0, last_hs = 0, n_words = 0;
  go_t           exp_go[$];
  logic [DW:0]   exp_w[$];
  logic [DW-1:0] fifo[$];
  always @(posedge clk) cyc++;
  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask
  task automatic exp_chunk(input logic [AW-1:0] b, input logic [AW-1:0] l, input bit fin);
    exp_go.push_back({b, l});
    for (int i = 0; i < int'(l / 2); i++) begin
      logic [AW-1:0] a;
      a = b + AW'(2 * i);
      exp_w.push_back({fin && (i == int'(l / 2) - 1), a[DW:1]});
    end
  endtask
  task automatic send_cmd(input logic [AW-1:0] b, input logic [AW-1:0] l);
    int t = 0;
    while (!sif.cmd_ready && t < 100) begin @(posedge clk); #1; t++; end
    chk("cmd_ready_before", sif.cmd_ready, 1);
    sif.cmd_base = b; sif.cmd_length = l; sif.cmd_valid = 1'b1;
    @(posedge clk); #1;
    sif.cmd_valid = 1'b0;
    chk("cmd_ready_after_accept", sif.cmd_ready, 0);
  endtask
  task automatic wait_done(input bit words, input int budget);
    int t = 0;
    bit seen = 0;
    while (t < budget && !seen) begin @(negedge clk); t++; seen = sif.xfer_done; end
    chk("xfer_done_seen", seen, 1);
    if (seen) begin
      chk("busy_at_done", sif.busy, 0);
      if (words) chk("done_latency", cyc - last_hs, 1);
      chk("words_outstanding", exp_w.size(), 0);
      chk("gos_outstanding", exp_go.size(), 0);
      @(negedge clk);
      chk("done_pulse_width", sif.xfer_done, 0);
      chk("cmd_ready_idle", sif.cmd_ready, 1);
    end
  endtask
  // Read master plus show-ahead buffer: one word per cycle, skipping every third cycle.
  initial begin
    bit pop, go, dn;
    logic [AW-1:0] gb, gl, pend_addr;
    int pend_n;
    go_t e;
    pend_n = 0; pend_addr = '0;
    sif.rm_done = 1'b1; sif.rm_data = '0; sif.rm_data_available = 1'b0; sif.rm_early_done = 1'b0;
    forever begin
      @(posedge clk);
      pop = sif.rm_read_buffer; go = sif.rm_go; dn = sif.rm_done;
      gb = sif.rm_read_base; gl = sif.rm_read_length;
      #1;
      if (!rst_n) begin
        fifo.delete(); pend_n = 0; sif.rm_done = 1'b1;
      end else begin
        if (pop) begin
          if (fifo.size() == 0) chk("pop_nonempty", 0, 1);
          else void'(fifo.pop_front());
        end
        if (go) begin
          chk("go_with_rm_done", dn, 1);
          if (exp_go.size() == 0) chk("unexpected_go_len", gl, 0);
          else begin
            e = exp_go.pop_front();
            chk("go_base", gb, e.b);
            chk("go_len", gl, e.l);
          end
          pend_addr = gb; pend_n = int'(gl / 2); sif.rm_done = (pend_n == 0);
        end else if (pend_n > 0 && cyc % 3 != 0) begin
          fifo.push_back(pend_addr[DW:1]);
          pend_addr += 2; pend_n--;
          if (pend_n == 0) sif.rm_done = 1'b1;
        end
      end
      sif.rm_data_available = (fifo.size() != 0);
      sif.rm_data = (fifo.size() != 0) ? fifo[0] : '0;
    end
  end
  // Output monitor: scoreboard pops plus backpressure invariants.
  initial begin
    bit pv, pr;
    logic [DW-1:0] pd;
    logic [DW:0] e;
    pv = 0; pr = 0; pd = '0;
    forever begin
      @(negedge clk);
      if (sif.m_valid && sif.m_ready) begin
        last_hs = cyc; n_words++;
        if (exp_w.size() == 0) chk("extra_word", sif.m_data, -1);
        else begin
          e = exp_w.pop_front();
          chk("m_data", sif.m_data, e[DW-1:0]);
          chk("m_last", sif.m_last, e[DW]);
        end
      end
      if (rst_n && pv && !pr) begin
        chk("stall_hold_valid", sif.m_valid, 1);
        chk("stall_hold_data", sif.m_data, pd);
      end
      if (sif.m_valid && !sif.m_ready) chk("stall_no_pop", sif.rm_read_buffer, 0);
      pv = rst_n && sif.m_valid; pr = sif.m_ready; pd = sif.m_data;
    end
  end
  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $display("%0d/%0d checks passed", n_pass, n_chk + 1);
    $fatal(1);
  end
  initial begin
    int w0;
    sif.cmd_valid = 1'b0; sif.cmd_base = '0; sif.cmd_length = '0; sif.m_ready = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_cmd_ready", sif.cmd_ready, 1);
    chk("rst_busy", sif.busy, 0);
    chk("rst_m_valid", sif.m_valid, 0);
    chk("rst_rm_go", sif.rm_go, 0);
    chk("rst_xfer_done", sif.xfer_done, 0);
    chk("rst_rm_read_buffer", sif.rm_read_buffer, 0);
    chk("rst_fixed_location", sif.rm_fixed_location, 0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    // single short chunk
    w0 = n_words;
    exp_chunk(25'h100, 25'd8, 1);
    send_cmd(25'h100, 25'd8);
    chk("t1_busy", sif.busy, 1);
    wait_done(1, 200);
    chk("t1_word_count", n_words - w0, 4);
`ifdef SDRAM_SEQ_CHECKSUM_EN
    chk("t1_checksum", sif.checksum, 16'h0206);
`endif
    // multi-chunk with ignored command while busy
    w0 = n_words;
    exp_chunk(25'h40000, 25'd4096, 0);
    exp_chunk(25'h41000, 25'd4096, 0);
    exp_chunk(25'h42000, 25'd1808, 1);
    send_cmd(25'h40000, 25'd10000);
    sif.cmd_base = 25'h777; sif.cmd_length = 25'd64; sif.cmd_valid = 1'b1;
    repeat (50) @(posedge clk);
    #1 sif.cmd_valid = 1'b0;
    wait_done(1, 20000);
    chk("t2_word_count", n_words - w0, 5000);
    // 20-cycle backpressure mid-chunk
    exp_chunk(25'h2000, 25'd64, 1);
    send_cmd(25'h2000, 25'd64);
    fork
      begin
        repeat (12) @(posedge clk);
        #1 sif.m_ready = 1'b0;
        repeat (20) @(posedge clk);
        #1 sif.m_ready = 1'b1;
      end
    join_none
    wait_done(1, 500);
    // zero-length and sub-word lengths
    w0 = n_words;
    send_cmd(25'h500, 25'd0);
    wait_done(0, 50);
    send_cmd(25'h500, 25'd1);
    wait_done(0, 50);
    chk("t4_word_count", n_words - w0, 0);
    // asynchronous reset during RUN
    exp_chunk(25'h3000, 25'd400, 1);
    send_cmd(25'h3000, 25'd400);
    repeat (30) @(posedge clk);
    #4 rst_n = 1'b0;
    #1;
    chk("arst_m_valid", sif.m_valid, 0);
    chk("arst_m_last", sif.m_last, 0);
    chk("arst_m_data", sif.m_data, 0);
    chk("arst_busy", sif.busy, 0);
    chk("arst_rm_go", sif.rm_go, 0);
    chk("arst_rm_read_buffer", sif.rm_read_buffer, 0);
    chk("arst_rm_read_length", sif.rm_read_length, 0);
    chk("arst_rm_read_base", sif.rm_read_base, 0);
    chk("arst_xfer_done", sif.xfer_done, 0);
    chk("arst_cmd_ready", sif.cmd_ready, 1);
    repeat (3) @(posedge clk);
    exp_go.delete(); exp_w.delete();
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    exp_chunk(25'h102, 25'd8, 1);
    send_cmd(25'h103, 25'd9);
    wait_done(1, 200);
    // checksum vector 0x0001..0x0004
    exp_chunk(25'h2, 25'd8, 1);
    send_cmd(25'h2, 25'd8);
    wait_done(1, 200);
`ifdef SDRAM_SEQ_CHECKSUM_EN
    chk("t6_checksum", sif.checksum, 16'h000A);
`endif
    repeat (5) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
